// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the 7-segment display scheduler.
// Segment bit order: [0]=a .. [6]=g, [7]=dp, all active-high.
package seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t GLYPH_0    = 8'h3F;
  localparam seg_t GLYPH_1    = 8'h06;
  localparam seg_t GLYPH_2    = 8'h5B;
  localparam seg_t GLYPH_3    = 8'h4F;
  localparam seg_t GLYPH_4    = 8'h66;
  localparam seg_t GLYPH_5    = 8'h6D;
  localparam seg_t GLYPH_6    = 8'h7D;
  localparam seg_t GLYPH_7    = 8'h07;
  localparam seg_t GLYPH_8    = 8'h7F;
  localparam seg_t GLYPH_9    = 8'h67;
  localparam seg_t GLYPH_A    = 8'h77;
  localparam seg_t GLYPH_B    = 8'h7C;
  localparam seg_t GLYPH_C    = 8'h39;
  localparam seg_t GLYPH_D    = 8'h5E;
  localparam seg_t GLYPH_E    = 8'h79;
  localparam seg_t GLYPH_F    = 8'h71;
  localparam seg_t GLYPH_DASH = 8'h40;

  typedef enum logic {IDLE, SHOW} sched_state_t;

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble -> a..g decoder. With SEG_HEX_EN defined, 10..15 show
// as A b C d E F; otherwise they show as a dash.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segs
);

  seg_t glyph;

  always_comb begin
    // NOTE: default assignment first so every path drives glyph; no latch is inferred.
    glyph = GLYPH_DASH;
    case (digit)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
`ifdef SEG_HEX_EN
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
`endif
      default: glyph = GLYPH_DASH;
    endcase
    segs = glyph[6:0];
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin scheduler sharing one 7-segment display among NREQ requesters;
// each grant is latched and shown for DWELL cycles. Hex glyphs via SEG_HEX_EN.
module seg_display_scheduler
  import seg_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DWELL = 4
) (
  input  logic                      clk_2,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [3:0]                val [NREQ],
  input  logic [NREQ-1:0]           dp_in,
  output logic [NREQ-1:0]           ack,
  output logic [7:0]                SEG,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(DWELL + 1);

  sched_state_t   state_q, state_d;
  seg_t           seg_q, seg_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [OW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           found;
  logic [OW-1:0]  win;
  int             scan_idx;
  logic [6:0]     win_segs;

  // Scan ptr, ptr+1, ... wrapping at NREQ; first active request wins.
  always_comb begin
    found    = 1'b0;
    win      = ptr_q;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = OW'(scan_idx);
      end
    end
  end

  seg_decoder u_decoder (
    .digit (val[win]),
    .segs  (win_segs)
  );

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    ack_d   = '0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE || cnt_q == '0) begin
      if (found) begin
        state_d = SHOW;
        seg_d   = {dp_in[win], win_segs};
        ack_d   = NREQ'(1) << win;
        owner_d = win;
        cnt_d   = CW'(DWELL - 1);
        ptr_d   = (win == OW'(NREQ - 1)) ? '0 : win + OW'(1);
      end else begin
        state_d = IDLE;
        seg_d   = '0;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seg_q   <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SEG   = seg_q;
  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = (state_q == SHOW);

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler (NREQ=4, DWELL=4); expected hex
// glyphs follow SEG_HEX_EN.
module tb_seg_display_scheduler;

  logic       clk_2 = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] val [4];
  logic [3:0] dp_in;
  logic [3:0] ack;
  logic [7:0] SEG;
  logic [1:0] owner;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;

  // Observed tuple: {SEG, ack, owner, busy}
  logic [14:0] obs;
  logic [14:0] exp_v;
  assign obs = {SEG, ack, owner, busy};

  localparam logic [7:0] DIG_TAB [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h67,
`ifdef SEG_HEX_EN
    8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
`else
    8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40
`endif
  };

  always #5 clk_2 = ~clk_2;

  seg_display_scheduler #(.NREQ(4), .DWELL(4)) dut (
    .clk_2 (clk_2),
    .rst_n (rst_n),
    .req   (req),
    .val   (val),
    .dp_in (dp_in),
    .ack   (ack),
    .SEG   (SEG),
    .owner (owner),
    .busy  (busy)
  );

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    dp_in = '0;
    for (int i = 0; i < 4; i++) val[i] = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'hF;
    dp_in = 4'hF;
    for (int i = 0; i < 4; i++) val[i] = 4'(i + 1);
    #1;
    for (int c = 0; c < 4; c++) begin
      exp_v = '0;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset cycle %0d: got %h expected %h", c, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; val[2] = 4'd3; dp_in[2] = 1'b1;
    tick();
    exp_v = {8'hCF, 4'b0100, 2'd2, 1'b1};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL single_grant: got %h expected %h", obs, exp_v);
    end
    req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp_v = {8'hCF, 4'b0000, 2'd2, 1'b1};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL single_hold %0d: got %h expected %h", c, obs, exp_v);
      end
    end
    tick();
    exp_v = {8'h00, 4'b0000, 2'd2, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL single_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] gl [4];
    int w;
    gl = '{8'h06, 8'h5B, 8'h4F, 8'h66};
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 4; i++) val[i] = 4'(i + 1);
    for (int g = 0; g < 5; g++) begin
      w = g % 4;
      tick();
      exp_v = {gl[w], 4'(1 << w), 2'(w), 1'b1};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL fair_grant %0d: got %h expected %h", g, obs, exp_v);
      end
      for (int c = 0; c < 3; c++) begin
        tick();
        exp_v = {gl[w], 4'b0000, 2'(w), 1'b1};
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL fair_hold %0d.%0d: got %h expected %h", g, c, obs, exp_v);
        end
      end
    end
    req = '0;
    tick();
    exp_v = {8'h00, 4'b0000, 2'd0, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL fair_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    int ord [3];
    logic [7:0] gl [3];
    ord = '{1, 3, 1};
    gl  = '{8'h07, 8'h5B, 8'h07};
    do_reset();
    req = 4'b1010; val[1] = 4'd7; val[3] = 4'd2;
    for (int g = 0; g < 3; g++) begin
      tick();
      exp_v = {gl[g], 4'(1 << ord[g]), 2'(ord[g]), 1'b1};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_grant %0d: got %h expected %h", g, obs, exp_v);
      end
      repeat (3) tick();
      exp_v = {gl[g], 4'b0000, 2'(ord[g]), 1'b1};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_hold %0d: got %h expected %h", g, obs, exp_v);
      end
    end
    req = '0;
    tick();
    exp_v = {8'h00, 4'b0000, 2'd1, 1'b0};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL b2b_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_mid_show();
    do_reset();
    req = 4'b0001; val[0] = 4'd5;
    tick();
    exp_v = {8'h6D, 4'b0001, 2'd0, 1'b1};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL mid_grant: got %h expected %h", obs, exp_v);
    end
    val[0] = 4'd8; dp_in = 4'hF; req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp_v = {8'h6D, 4'b0000, 2'd0, 1'b1};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL mid_hold %0d: got %h expected %h", c, obs, exp_v);
      end
    end
    tick();
    exp_v = '0;
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL mid_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_hex();
    do_reset();
    req = 4'b0010; val[1] = 4'hA;
    tick();
`ifdef SEG_HEX_EN
    exp_v = {8'h77, 4'b0010, 2'd1, 1'b1};
`else
    exp_v = {8'h40, 4'b0010, 2'd1, 1'b1};
`endif
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL hex_a: got %h expected %h", obs, exp_v);
    end
    req = '0;
    repeat (4) tick();
  endtask

  task automatic test_digits();
    int r;
    do_reset();
    for (int d = 0; d < 16; d++) begin
      r = d % 4;
      val[r]   = 4'(d);
      dp_in    = '0;
      dp_in[r] = 1'(d % 2);
      req      = 4'(1 << r);
      tick();
      exp_v = {1'(d % 2), DIG_TAB[d][6:0], 4'(1 << r), 2'(r), 1'b1};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL digit %0d: got %h expected %h", d, obs, exp_v);
      end
      req = '0;
      repeat (4) tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100; val[2] = 4'd6;
    tick();
    req = '0;
    tick();
    exp_v = {8'h7D, 4'b0000, 2'd2, 1'b1};
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL arst_pre: got %h expected %h", obs, exp_v);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_v = '0;
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL arst_immediate: got %h expected %h", obs, exp_v);
    end
    tick();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL arst_held: got %h expected %h", obs, exp_v);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    dp_in = '0;
    for (int i = 0; i < 4; i++) val[i] = '0;
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_mid_show();
    test_hex();
    test_digits();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
